eucl_prog_seq: RTL and testbench

EUCL_PROG_SEQ -- requirements
Module: eucl_prog_seq

---
 rtl/eucl_prog_seq.sv | 128 ++++++++++++
 tb/tb_eucl_prog_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/eucl_prog_seq.sv
// eucl_prog_seq: loads a program of up to 16 instruction words and sequences
// them to eucl, following the program counter eucl returns each run cycle.
module eucl_prog_seq #(
    parameter int IW         = 21,
    parameter int MAX_CYCLES = 200
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic          start,
    input  logic [3:0]    p_c_out,
    output logic [IW-1:0] pm_cont,
    output logic [3:0]    p_c,
    output logic          run,
    output logic          done,
    output logic          timeout,
    output logic [4:0]    prog_len,
    output logic [7:0]    cycle_cnt
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [7:0] LAST_CYC = 8'(MAX_CYCLES - 1);

    logic [IW-1:0] mem_q [16];
    logic [1:0]    state_q, state_d;
    logic [3:0]    wr_ptr_q, wr_ptr_d;
    logic [4:0]    prog_len_q, prog_len_d;
    logic [3:0]    p_c_q, p_c_d;
    logic [IW-1:0] pm_cont_q, pm_cont_d;
    logic [7:0]    cycle_q, cycle_d;
    logic          run_q, run_d, done_q, done_d, timeout_q, timeout_d;
    logic          idle_like, mem_we, end_fetch, time_up;
    logic [3:0]    mem_waddr;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign mem_we    = load_valid && (state_q != S_RUN);
    assign mem_waddr = (state_q == S_LOAD) ? wr_ptr_q : 4'd0;
    assign end_fetch = {1'b0, p_c_out} >= prog_len_q;
    assign time_up   = cycle_q == LAST_CYC;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        p_c_d      = p_c_q;
        pm_cont_d  = pm_cont_q;
        cycle_d    = cycle_q;
        run_d      = run_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        if (idle_like && load_valid) begin
            wr_ptr_d   = 4'd1;
            prog_len_d = load_last ? 5'd1 : 5'd0;
            done_d     = 1'b0;
            timeout_d  = 1'b0;
            state_d    = load_last ? S_IDLE : S_LOAD;
        end else if (idle_like && start && prog_len_q != 5'd0) begin
            state_d   = S_RUN;
            p_c_d     = 4'd0;
            pm_cont_d = mem_q[0];
            cycle_d   = 8'd0;
            run_d     = 1'b1;
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end else if (state_q == S_LOAD && load_valid) begin
            wr_ptr_d = wr_ptr_q + 4'd1;
            if (load_last || wr_ptr_q == 4'd15) begin
                prog_len_d = {1'b0, wr_ptr_q} + 5'd1;
                state_d    = S_IDLE;
            end
        end else if (state_q == S_RUN) begin
            // Termination freezes cycle_cnt at the cycle that ended the run.
            if (end_fetch || time_up) begin
                state_d   = S_DONE;
                pm_cont_d = '0;
                run_d     = 1'b0;
                done_d    = 1'b1;
                timeout_d = time_up;
            end else begin
                p_c_d     = p_c_out;
                pm_cont_d = mem_q[p_c_out];
                cycle_d   = (&cycle_q) ? cycle_q : cycle_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem_q[mem_waddr] <= load_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            p_c_q      <= '0;
            pm_cont_q  <= '0;
            cycle_q    <= '0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            p_c_q      <= p_c_d;
            pm_cont_q  <= pm_cont_d;
            cycle_q    <= cycle_d;
            run_q      <= run_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign load_ready = state_q != S_RUN;
    assign pm_cont    = pm_cont_q;
    assign p_c        = p_c_q;
    assign run        = run_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign prog_len   = prog_len_q;
    assign cycle_cnt  = cycle_q;
endmodule

// File: tb/tb_eucl_prog_seq.sv
// tb_eucl_prog_seq: directed load/run scenarios with a queue of expected fetches.
module tb_eucl_prog_seq;
    logic        clock = 1'b0, reset_n = 1'b0;
    logic        load_valid = 1'b0, load_last = 1'b0, start = 1'b0;
    logic [20:0] load_data = '0;
    logic [3:0]  p_c_out = '0;
    logic        load_ready, run, done, timeout;
    logic [20:0] pm_cont;
    logic [3:0]  p_c;
    logic [4:0]  prog_len;
    logic [7:0]  cycle_cnt;

    typedef struct {logic [20:0] pm; logic [3:0] pc; logic run; logic done;} exp_t;
    exp_t        sb[$];
    logic [20:0] mdl [16];
    int          m_len, checks, errors;
    logic [3:0]  m_pc;

    eucl_prog_seq dut (
        .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .start(start), .p_c_out(p_c_out),
        .pm_cont(pm_cont), .p_c(p_c), .run(run), .done(done), .timeout(timeout),
        .prog_len(prog_len), .cycle_cnt(cycle_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [20:0] d, input logic last);
        mdl[addr]  = d;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        m_pc = 4'd0;
        chk("start_run", {31'd0, run}, 32'd1);
        chk("start_pc", {28'd0, p_c}, 32'd0);
        chk("start_pm", {11'd0, pm_cont}, {11'd0, mdl[0]});
        chk("start_cyc", {24'd0, cycle_cnt}, 32'd0);
        chk("start_rdy", {31'd0, load_ready}, 32'd0);
    endtask

    // Each returned counter is scored against the bench's own view of the program.
    task automatic fetch(input logic [3:0] v);
        exp_t e, o;
        if (int'(v) < m_len) begin
            e = '{pm: mdl[v], pc: v, run: 1'b1, done: 1'b0};
            m_pc = v;
        end else e = '{pm: '0, pc: m_pc, run: 1'b0, done: 1'b1};
        sb.push_back(e);
        p_c_out = v;
        step();
        o = sb.pop_front();
        chk("fetch_pm", {11'd0, pm_cont}, {11'd0, o.pm});
        chk("fetch_pc", {28'd0, p_c}, {28'd0, o.pc});
        chk("fetch_run", {31'd0, run}, {31'd0, o.run});
        chk("fetch_done", {31'd0, done}, {31'd0, o.done});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_len"}, {27'd0, prog_len}, 32'd0);
        chk({tag, "_pc"}, {28'd0, p_c}, 32'd0);
        chk({tag, "_pm"}, {11'd0, pm_cont}, 32'd0);
        chk({tag, "_flags"}, {29'd0, run, done, timeout}, 32'd0);
        chk({tag, "_cyc"}, {24'd0, cycle_cnt}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, load_ready}, 32'd1);
    endtask

    initial begin
        #12;
        chk_reset_vals("reset");
        #5 reset_n = 1'b1;
        step();
        // Basic two-word program and end fetch.
        load_word(0, 21'h0A8C02, 1'b0);
        chk("load_rdy", {31'd0, load_ready}, 32'd1);
        chk("load_len0", {27'd0, prog_len}, 32'd0);
        load_word(1, 21'h0A8C0A, 1'b1);
        chk("len2", {27'd0, prog_len}, 32'd2);
        m_len = 2;
        start_run();
        fetch(4'd1);
        chk("cyc1", {24'd0, cycle_cnt}, 32'd1);
        fetch(4'd2);
        chk("end_timeout", {31'd0, timeout}, 32'd0);
        // Start colliding with load in DONE: load wins.
        load_valid = 1'b1; start = 1'b1; load_data = 21'h1ABCDE; mdl[0] = 21'h1ABCDE;
        step();
        load_valid = 1'b0; start = 1'b0;
        chk("collide_run", {31'd0, run}, 32'd0);
        chk("collide_len", {27'd0, prog_len}, 32'd0);
        chk("collide_done", {31'd0, done}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load_start_ign", {31'd0, run}, 32'd0);
        load_word(1, 21'h055555, 1'b0);
        load_word(2, 21'h0F0F0F, 1'b1);
        chk("len3", {27'd0, prog_len}, 32'd3);
        m_len = 3;
        start_run();
        fetch(4'd2); fetch(4'd0); fetch(4'd1); fetch(4'd1); fetch(4'd2); fetch(4'd3);
        // Sixteen words with no last marker.
        for (int i = 0; i < 16; i++) begin
            load_word(i, 21'($urandom), 1'b0);
            if (i < 15) chk("load16_len", {27'd0, prog_len}, 32'd0);
        end
        chk("len16", {27'd0, prog_len}, 32'd16);
        chk("len16_rdy", {31'd0, load_ready}, 32'd1);
        m_len = 16;
        start_run();
        fetch(4'd15); fetch(4'd7); fetch(4'd15);
        // Branch-to-self at 0 until the cycle limit forces the end.
        p_c_out = 4'd0;
        for (int k = 4; k <= 200; k++) begin
            step();
            if (k < 200) begin
                chk("to_pm", {11'd0, pm_cont}, {11'd0, mdl[0]});
                chk("to_cyc", {24'd0, cycle_cnt}, k);
                chk("to_run", {31'd0, run}, 32'd1);
            end
        end
        chk("to_flags", {29'd0, run, done, timeout}, 32'd3);
        chk("to_cyc_end", {24'd0, cycle_cnt}, 32'd199);
        chk("to_pm_end", {11'd0, pm_cont}, 32'd0);
        // A seventeenth word restarts storage at address 0.
        load_word(0, 21'h13579B, 1'b1);
        chk("len1", {27'd0, prog_len}, 32'd1);
        chk("reload_flags", {29'd0, run, done, timeout}, 32'd0);
        m_len = 1;
        start_run();
        fetch(4'd0); fetch(4'd0);
        // Asynchronous reset mid-run, then a start with nothing loaded.
        #2 reset_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        #3 reset_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rst_start_ign", {31'd0, run}, 32'd0);
        chk("rst_start_pm", {11'd0, pm_cont}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
